// File: rtl/dds2note_pitch.sv
// Converts a DDS phase increment back into the nearest-below MIDI note plus a
// 14-bit pitch-wheel value, using a binary search and a restoring division.

module note2dds (
  input  logic        clk,
  input  logic [6:0]  note,
  output logic [31:0] adder
);

  logic [10:0] base;
  logic [3:0]  octave;
  logic [3:0]  semi;

  // Lowest-octave increments for a 50 MHz clock; higher octaves are left shifts.
  always_comb begin
    octave = 4'(note / 7'd12);
    semi   = 4'(note % 7'd12);
    case (semi)
      4'd0:    base = 11'd702;
      4'd1:    base = 11'd744;
      4'd2:    base = 11'd788;
      4'd3:    base = 11'd835;
      4'd4:    base = 11'd885;
      4'd5:    base = 11'd937;
      4'd6:    base = 11'd993;
      4'd7:    base = 11'd1052;
      4'd8:    base = 11'd1115;
      4'd9:    base = 11'd1181;
      4'd10:   base = 11'd1251;
      default: base = 11'd1326;
    endcase
  end

  always_ff @(posedge clk) begin
    adder <= 32'(base) << octave;
  end

endmodule

module dds2note_pitch #(
  parameter int LAT          = 28,
  parameter int PITCH_CENTER = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] adder_in,
  output logic [6:0]  note,
  output logic [13:0] pitch,
  output logic        clip_lo,
  output logic        clip_hi,
  output logic        out_valid
);

  typedef enum logic [2:0] {IDLE, SRCH, RD_LO, RD_HI, PREP, DIV, OUT} state_t;

  state_t      state, state_nxt;
  logic [3:0]  step;
  logic [31:0] a_reg, t_lo, t_hi, t_q;
  logic [6:0]  idx, trial, addr;
  logic [2:0]  bit_sel;
  logic [32:0] num, den;
  logic [33:0] shifted;
  logic [7:0]  quo;
  logic [17:0] prod;
  logic        cl_lo, cl_hi;

  note2dds u_table (
    .clk   (clk),
    .note  (addr),
    .adder (t_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = SRCH;
      SRCH:    if (step == 4'd13) state_nxt = RD_LO;
      RD_LO:   if (step == 4'd1)  state_nxt = RD_HI;
      RD_HI:   if (step == 4'd1)  state_nxt = PREP;
      PREP:                       state_nxt = DIV;
      DIV:     if (step == 4'd7)  state_nxt = OUT;
      OUT:                        state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  // Index 127 is never a search candidate; the address is held at 126 instead.
  always_comb begin
    bit_sel = 3'd6 - 3'(step >> 1);
    trial   = idx | (7'd1 << bit_sel);
    case (state)
      SRCH:    addr = (trial == 7'd127) ? 7'd126 : trial;
      RD_LO:   addr = idx;
      RD_HI:   addr = idx + 7'd1;
      default: addr = 7'd0;
    endcase
    shifted = {num, 1'b0};
    prod    = 18'(quo) * 18'd683;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step      <= '0;
      a_reg     <= '0;
      idx       <= '0;
      t_lo      <= '0;
      t_hi      <= '0;
      num       <= '0;
      den       <= '0;
      quo       <= '0;
      cl_lo     <= 1'b0;
      cl_hi     <= 1'b0;
      note      <= '0;
      pitch     <= 14'(PITCH_CENTER);
      clip_lo   <= 1'b0;
      clip_hi   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      step      <= (state != state_nxt) ? 4'd0 : step + 4'd1;
      out_valid <= (state == OUT);
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= adder_in;
          idx   <= '0;
        end
        SRCH: if (step[0] && trial != 7'd127 && t_q <= a_reg) idx <= trial;
        RD_LO: if (step[0]) t_lo <= t_q;
        RD_HI: if (step[0]) t_hi <= t_q;
        PREP: begin
          cl_lo <= (a_reg < t_lo);
          cl_hi <= (idx == 7'd126) && (a_reg >= t_hi);
          // Clipped inputs divide a zero numerator so the quotient stays in range.
          if (a_reg < t_lo || a_reg >= t_hi) num <= '0;
          else num <= {1'b0, a_reg} - {1'b0, t_lo};
          den <= {1'b0, t_hi} - {1'b0, t_lo};
          quo <= '0;
        end
        DIV: begin
          if (shifted >= {1'b0, den}) begin
            num <= 33'(shifted - {1'b0, den});
            quo <= {quo[6:0], 1'b1};
          end else begin
            num <= shifted[32:0];
            quo <= {quo[6:0], 1'b0};
          end
        end
        OUT: begin
          note    <= cl_hi ? 7'd127 : idx;
          pitch   <= (cl_lo || cl_hi) ? 14'(PITCH_CENTER)
                                      : 14'(PITCH_CENTER) + {4'd0, prod[17:8]};
          clip_lo <= cl_lo;
          clip_hi <= cl_hi;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dds2note_pitch.sv
// Directed-vector bench for dds2note_pitch; a scoreboard queue holds expected
// results and a monitor checks them whenever out_valid is seen.

module tb_dds2note_pitch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] adder_in = '0;
  logic [6:0]  note;
  logic [13:0] pitch;
  logic        clip_lo, clip_hi, out_valid;

  typedef struct {
    logic [6:0]  note;
    logic [13:0] pitch;
    logic        lo;
    logic        hi;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   last_ov = 0;

  dds2note_pitch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .adder_in  (adder_in),
    .note      (note),
    .pitch     (pitch),
    .clip_lo   (clip_lo),
    .clip_hi   (clip_hi),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      last_ov = cyc;
      if (sb.size() == 0) begin
        check_output("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check_output("note", note, e.note);
        check_output("pitch", pitch, e.pitch);
        check_output("clip_lo", clip_lo, e.lo);
        check_output("clip_hi", clip_hi, e.hi);
        check_output("latency", cyc - e.acc, 28);
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] a, input logic [6:0] n,
                                input logic [13:0] p, input logic lo,
                                input logic hi, input bit push);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    adder_in = a;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_output("accept_timeout", 0, 1);
    end else begin
      last_acc = cyc + 1;
      if (push) begin
        e.note = n; e.pitch = p; e.lo = lo; e.hi = hi; e.acc = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic release_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_output("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc1;
    int rst_at;
    repeat (3) @(negedge clk);
    check_output("reset_note", note, 0);
    check_output("reset_pitch", pitch, 8192);
    check_output("reset_in_ready", in_ready, 1);
    check_output("reset_out_valid", out_valid, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_output("idle_no_out_valid", last_ov, 0);
    check_output("idle_in_ready", in_ready, 1);

    apply_stimulus(32'd37792,   7'd69,  14'd8192, 1'b0, 1'b0, 1); release_in(); drain();
    apply_stimulus(32'd23136,   7'd60,  14'd8533, 1'b0, 1'b0, 1); release_in(); drain();
    apply_stimulus(32'd0,       7'd0,   14'd8192, 1'b1, 1'b0, 1); release_in(); drain();
    apply_stimulus(32'hFFFFFFFF,7'd127, 14'd8192, 1'b0, 1'b1, 1); release_in(); drain();
    apply_stimulus(32'd701,     7'd0,   14'd8192, 1'b1, 1'b0, 1); release_in(); drain();
    apply_stimulus(32'd702,     7'd0,   14'd8192, 1'b0, 1'b0, 1); release_in(); drain();
    apply_stimulus(32'd1346,    7'd11,  14'd8365, 1'b0, 1'b0, 1); release_in(); drain();
    apply_stimulus(32'd1077247, 7'd126, 14'd8872, 1'b0, 1'b0, 1); release_in(); drain();
    apply_stimulus(32'd1077248, 7'd127, 14'd8192, 1'b0, 1'b1, 1); release_in(); drain();

    apply_stimulus(32'd1251,    7'd10,  14'd8192, 1'b0, 1'b0, 1);
    acc1 = last_acc;
    apply_stimulus(32'd226560,  7'd100, 14'd8192, 1'b0, 1'b0, 1);
    check_output("b2b_accept_gap", last_acc - acc1, 29);
    release_in();
    drain();

    // Abort a conversion mid-search; it must never report.
    apply_stimulus(32'd37792,   7'd69,  14'd8192, 1'b0, 1'b0, 0);
    release_in();
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    rst_at = cyc;
    @(negedge clk);
    check_output("abort_note", note, 0);
    check_output("abort_pitch", pitch, 8192);
    check_output("abort_clip_hi", clip_hi, 0);
    check_output("abort_out_valid", out_valid, 0);
    check_output("abort_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_output("abort_no_out_valid", last_ov < rst_at, 1);

    apply_stimulus(32'd23136,   7'd60,  14'd8533, 1'b0, 1'b0, 1); release_in(); drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds2note_pitch.md
Name: dds2note_pitch

Overview:
- Inverse of the note+pitch-wheel → DDS phase-increment path.
- Takes a 32-bit DDS adder (phase increment) and recovers the nearest-below MIDI note plus a 14-bit pitch-wheel value.
- The pitch value, fed back through the forward path, approximately reproduces the input frequency.
- Used for tuner display, MIDI-out of detected/modulated frequencies, and round-trip checks of the forward converter.
- Finds the note by binary search over the shared note2dds table, then does a sequential restoring division for the fractional semitone.

Parameters:
- LAT, 28, fixed input-accept-to-out_valid latency in clk cycles; informational, not to be changed.
- PITCH_CENTER, 8192, pitch-wheel value meaning zero bend.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request strobe, qualifies adder_in
- in_ready  out  1  high when block is idle and can accept
- adder_in  in  32  DDS phase increment to convert
- note  out  7  recovered MIDI note, 0..127
- pitch  out  14  recovered pitch-wheel value
- clip_lo  out  1  adder_in was below table[0]
- clip_hi  out  1  adder_in was at or above table[127]
- out_valid  out  1  one-cycle pulse, results updated

Behaviour:
- One clock (clk), asynchronous active-low reset (rst_n).
- Reset values:
  - note=0, pitch=8192, clip_lo=0, clip_hi=0, out_valid=0.
  - in_ready=1; FSM in IDLE.
  - All internal registers cleared.
- Reset mid-operation aborts the conversion; no out_valid is produced.
- Table: one internal note2dds instance (clk, 7-bit note address, 32-bit adder), one-cycle registered read latency. T[n] denotes its entry. T is strictly increasing.
- Handshake:
  - Accept occurs on a rising edge where in_valid && in_ready; adder_in is latched.
  - in_ready is high only in IDLE. in_valid while busy is ignored, not queued.
- FSM and cycle timing (edge 0 = accept):
  - SRCH, edges 1..14: 7 iterations of 2 cycles each (drive address, compare the registered T).
    - Find the largest n in 0..126 with T[n] <= A. Bit-serial MSB-first on a 7-bit index, capped at 126.
  - RD_LO, edges 15..16: read T[n].
  - RD_HI, edges 17..18: read T[n+1].
  - PREP, edge 19:
    - num = A - T[n], den = T[n+1] - T[n], both 33-bit unsigned.
    - Resolve clip flags.
  - DIV, edges 20..27: 8-step restoring division, f = floor(num*256/den). 8-bit result; num<den guarantees no overflow.
  - OUT, edge 28: register outputs and set out_valid. FSM returns to IDLE.
  - out_valid is high for exactly the cycle after edge 28. in_ready is high in that same cycle, so back-to-back requests are allowed.
- Pitch mapping (inverse of forward 3-per-count scaling, 682.67 pitch counts per semitone):
  - pitch = 8192 + ((f*683) >> 8), range 8192..8872.
  - Intermediate f*683 is 18 bits.
- Boundaries:
  - A < T[0]: note=0, pitch=8192, clip_lo=1.
  - A >= T[127]: note=127, pitch=8192, clip_hi=1.
  - A == T[n]: note=n, pitch=8192 exactly, no clip.
  - T[126] <= A < T[127]: note=126, interpolated against T[127].
- Latency is LAT in all cases, including clip cases; unused states still run.
- Outputs and clip flags hold their values until the next OUT edge. Clip flags are mutually exclusive.

Test Plan:
- Reset, then idle with no request → note=0, pitch=8192, out_valid never asserts, in_ready=1.
- adder_in=T[69], single in_valid → out_valid pulse exactly 28 cycles after accept; note=69, pitch=8192, clips 0.
- adder_in=(T[60]+T[61])/2 → note=60, f in 127..128, pitch 8530..8533.
- adder_in=0 → note=0, pitch=8192, clip_lo=1. adder_in=32'hFFFF_FFFF → note=127, pitch=8192, clip_hi=1.
- Back-to-back: assert in_valid continuously with T[10] then T[100] → second accept in the out_valid cycle of the first; results note=10, then note=100, 29 cycles apart.
- Assert rst_n low at cycle 12 of a conversion → outputs return to reset values, no out_valid; next request converts correctly.
